// File: rtl/fetch_unit.sv
// Instruction-fetch / PC stage: fetches over a req/ready handshake, holds the
// instruction until retirement, then commits the next PC or traps on a misaligned target.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc,
    input  logic        Jalr,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUResult,
    input  logic        retire,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] Instr,
    output logic        instr_valid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        misalign,
    output logic [31:0] bad_target,
    output logic [31:0] instret
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        TRAP  = 2'd3
    } state_e;

    state_e            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   instr_q;
    logic              req_q;
    logic              valid_q;
    logic              misalign_q;
    logic [XLEN-1:0]   bad_target_q;
    logic [XLEN-1:0]   instret_q;
    logic [XLEN-1:0]   next_pc_d;

    // Next-PC select; JALR target has its LSB cleared before the alignment check.
    always_comb begin
        next_pc_d = pc_q + XLEN'(4);
        if (PCSrc) begin
            if (Jalr) begin
                next_pc_d = ALUResult & 32'hFFFF_FFFE;
            end else begin
                next_pc_d = pc_q + ImmExt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INSTR;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
            misalign_q   <= 1'b0;
            bad_target_q <= '0;
            instret_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                end
                FETCH: begin
                    if (imem_ready) begin
                        instr_q <= imem_rdata;
                        state_q <= EXEC;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                EXEC: begin
                    if (retire) begin
                        instret_q <= instret_q + XLEN'(1);
                        valid_q   <= 1'b0;
                        if (next_pc_d[1:0] == 2'b00) begin
                            pc_q    <= next_pc_d;
                            state_q <= FETCH;
                            req_q   <= 1'b1;
                        end else begin
                            misalign_q   <= 1'b1;
                            bad_target_q <= next_pc_d;
                            state_q      <= TRAP;
                        end
                    end
                end
                TRAP: begin
                    state_q <= TRAP;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign PC          = pc_q;
    assign PCPlus4     = pc_q + XLEN'(4);
    assign Instr       = instr_q;
    assign instr_valid = valid_q;
    assign misalign    = misalign_q;
    assign bad_target  = bad_target_q;
    assign instret     = instret_q;

endmodule
